// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin sharing of one SPI master between NREQ requesters
// Each grant runs SETUP -> START -> WAIT -> GAP with a watchdog on the master's done pulse.
module spi_txn_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic [NREQ*2-1:0]          req_mode,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            ack,
  output logic                       err,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [NREQ-1:0]            ss_n,
  output logic [DATA_WIDTH-1:0]      m_din,
  output logic                       m_cpol,
  output logic                       m_cpha,
  output logic                       m_start,
  input  logic                       m_done,
  input  logic [DATA_WIDTH-1:0]      m_rx
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_WAIT, S_GAP} state_t;

  state_t                state_q;
  logic [PW-1:0]         ptr_q;
  logic [CW-1:0]         cnt_q;
  logic [NREQ-1:0]       gnt_q;
  logic [NREQ-1:0]       ack_q;
  logic [NREQ-1:0]       ss_n_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rsp_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  start_q;

  logic                  found_d;
  logic [PW-1:0]         win_d;
  logic [NREQ-1:0]       onehot_d;
  logic [DATA_WIDTH-1:0] din_d;
  logic [1:0]            mode_d;

  // Two passes give "first set bit above the pointer, else wrap to the lowest".
  always_comb begin
    found_d = 1'b0;
    win_d   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_d && req[i] && (PW'(i) > ptr_q)) begin
        found_d = 1'b1;
        win_d   = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found_d && req[i] && (PW'(i) <= ptr_q)) begin
        found_d = 1'b1;
        win_d   = PW'(i);
      end
    end
  end

  always_comb begin
    onehot_d = '0;
    din_d    = '0;
    mode_d   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win_d) begin
        onehot_d[i] = 1'b1;
        din_d       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        mode_d      = req_mode[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NREQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      ss_n_q  <= '1;
      err_q   <= 1'b0;
      rsp_q   <= '0;
      din_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      ack_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            gnt_q            <= onehot_d;
            ss_n_q           <= ~onehot_d;
            din_q            <= din_d;
            {cpol_q, cpha_q} <= mode_d;
            ptr_q            <= win_d;
            state_q          <= S_SETUP;
          end
        end
        S_SETUP: begin
          start_q <= 1'b1;
          state_q <= S_START;
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // Terminal count chosen so the abort ack lands TIMEOUT cycles after m_start.
          if (m_done || (cnt_q == CW'(TIMEOUT - 2))) begin
            ack_q   <= gnt_q;
            err_q   <= !m_done;
            rsp_q   <= m_done ? m_rx : '0;
            gnt_q   <= '0;
            ss_n_q  <= '1;
            cnt_q   <= '0;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign rsp_data = rsp_q;
  assign ss_n     = ss_n_q;
  assign m_din    = din_q;
  assign m_cpol   = cpol_q;
  assign m_cpha   = cpha_q;
  assign m_start  = start_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - self-checking bench for spi_txn_arbiter
module tb_spi_txn_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int GAP  = 2;
  localparam int TO   = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*2-1:0] req_mode;
  logic [NREQ-1:0]   gnt, ack, ss_n;
  logic              err, m_cpol, m_cpha, m_start, m_done;
  logic [DW-1:0]     rsp_data, m_din, m_rx;

  logic [DW-1:0]     rdata [NREQ];
  logic [1:0]        rmode [NREQ];

  int n_checks = 0;
  int n_pass   = 0;

  spi_txn_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_mode(req_mode),
    .gnt(gnt), .ack(ack), .err(err), .rsp_data(rsp_data), .ss_n(ss_n),
    .m_din(m_din), .m_cpol(m_cpol), .m_cpha(m_cpha), .m_start(m_start),
    .m_done(m_done), .m_rx(m_rx)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    req_mode = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = rdata[i];
      req_mode[2*i +: 2]   = rmode[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int gidx, output int waited);
    waited = 0;
    while (gnt == '0 && waited < 30) begin
      tick();
      waited++;
    end
    gidx = -1;
    for (int i = 0; i < NREQ; i++) if (gnt === NREQ'(1 << i)) gidx = i;
  endtask

  task automatic finish_xfer(input int delay, input logic [DW-1:0] rx,
                             output bit start_ok, output logic [DW-1:0] din_at_start);
    tick();
    start_ok     = (m_start === 1'b1);
    din_at_start = m_din;
    repeat (delay) tick();
    m_done = 1'b1;
    m_rx   = rx;
    tick();
    m_done = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; m_done = 1'b0; m_rx = '0;
    for (int i = 0; i < NREQ; i++) begin rdata[i] = '0; rmode[i] = '0; end
    repeat (3) tick();
    n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", gnt); else n_pass++;
    n_checks++; if (ack !== 4'b0000) $display("FAIL reset_ack got %b exp 0000", ack); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
    n_checks++; if (ss_n !== 4'b1111) $display("FAIL reset_ss_n got %b exp 1111", ss_n); else n_pass++;
    n_checks++; if (m_start !== 1'b0) $display("FAIL reset_m_start got %b exp 0", m_start); else n_pass++;
    n_checks++; if (m_din !== 8'h00) $display("FAIL reset_m_din got %h exp 00", m_din); else n_pass++;
    n_checks++; if ({m_cpol, m_cpha} !== 2'b00) $display("FAIL reset_mode got %b exp 00", {m_cpol, m_cpha}); else n_pass++;
    n_checks++; if (rsp_data !== 8'h00) $display("FAIL reset_rsp got %h exp 00", rsp_data); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int bad_ss = 0;
    req = 4'b0001; rdata[0] = 8'hA5; rmode[0] = 2'b01;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ss_n !== 4'b1110) bad_ss++;
      if (c == 1) begin
        n_checks++; if (gnt !== 4'b0001) $display("FAIL single_gnt got %b exp 0001", gnt); else n_pass++;
        n_checks++; if (m_din !== 8'hA5) $display("FAIL single_din got %h exp a5", m_din); else n_pass++;
        n_checks++; if ({m_cpol, m_cpha} !== 2'b01) $display("FAIL single_mode got %b exp 01", {m_cpol, m_cpha}); else n_pass++;
      end
      if (c == 2) begin
        n_checks++; if (m_start !== 1'b1) $display("FAIL single_start got %b exp 1", m_start); else n_pass++;
      end
      if (c == 3) begin
        n_checks++; if (m_start !== 1'b0) $display("FAIL single_start_width got %b exp 0", m_start); else n_pass++;
      end
      if (c == 20) begin m_done = 1'b1; m_rx = 8'h3C; end
    end
    tick();
    m_done = 1'b0;
    n_checks++; if (ack !== 4'b0001) $display("FAIL single_ack got %b exp 0001", ack); else n_pass++;
    n_checks++; if (rsp_data !== 8'h3C) $display("FAIL single_rsp got %h exp 3c", rsp_data); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL single_err got %b exp 0", err); else n_pass++;
    n_checks++; if (ss_n !== 4'b1111) $display("FAIL single_ss_release got %b exp 1111", ss_n); else n_pass++;
    n_checks++; if (bad_ss !== 0) $display("FAIL single_ss_hold got %0d bad cycles exp 0", bad_ss); else n_pass++;
    req = '0;
    tick();
    n_checks++; if (ack !== 4'b0000) $display("FAIL single_ack_pulse got %b exp 0000", ack); else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_round_robin();
    int g, w;
    bit sok;
    logic [DW-1:0] dst;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin rdata[i] = DW'(8'h10 + i); rmode[i] = 2'(i); end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, w);
      n_checks++; if (g !== k % NREQ) $display("FAIL rr_order got %0d exp %0d", g, k % NREQ); else n_pass++;
      n_checks++; if (m_din !== DW'(8'h10 + k % NREQ)) $display("FAIL rr_din got %h exp %h", m_din, DW'(8'h10 + k % NREQ)); else n_pass++;
      if (k > 0) begin
        n_checks++; if (w !== GAP + 1) $display("FAIL rr_gap got %0d idle cycles exp %0d", w, GAP + 1); else n_pass++;
      end
      finish_xfer(3, DW'(8'hC0 + k), sok, dst);
      n_checks++; if (ack !== NREQ'(1 << (k % NREQ))) $display("FAIL rr_ack got %b exp %b", ack, NREQ'(1 << (k % NREQ))); else n_pass++;
      n_checks++; if (rsp_data !== DW'(8'hC0 + k)) $display("FAIL rr_rsp got %h exp %h", rsp_data, DW'(8'hC0 + k)); else n_pass++;
      n_checks++; if (ss_n !== 4'b1111) $display("FAIL rr_ss_gap got %b exp 1111", ss_n); else n_pass++;
      if (k == 4) req = '0;
    end
    repeat (4) tick();
  endtask

  task automatic test_mode_switch();
    int g, w, n, bad;
    bit sok;
    logic [DW-1:0] dst;
    req = 4'b0001; rdata[0] = 8'h33; rmode[0] = 2'b00;
    wait_grant(g, w);
    n_checks++; if ({m_cpol, m_cpha} !== 2'b00) $display("FAIL mode_req0 got %b exp 00", {m_cpol, m_cpha}); else n_pass++;
    finish_xfer(2, 8'h44, sok, dst);
    req = 4'b0100; rdata[2] = 8'h77; rmode[2] = 2'b11;
    n = 0; bad = 0;
    while (gnt == '0 && n < 30) begin
      if ({m_cpol, m_cpha} !== 2'b00) bad++;
      tick();
      n++;
    end
    n_checks++; if (bad !== 0) $display("FAIL mode_early_change got %0d bad cycles exp 0", bad); else n_pass++;
    n_checks++; if (gnt !== 4'b0100) $display("FAIL mode_gnt2 got %b exp 0100", gnt); else n_pass++;
    n_checks++; if ({m_cpol, m_cpha} !== 2'b11) $display("FAIL mode_setup got %b exp 11", {m_cpol, m_cpha}); else n_pass++;
    finish_xfer(2, 8'h88, sok, dst);
    req = '0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if ({m_cpol, m_cpha} !== 2'b11 || m_din !== 8'h77) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) $display("FAIL mode_hold got %0d bad cycles exp 0", bad); else n_pass++;
  endtask

  task automatic test_timeout();
    int g, w, early;
    req = 4'b0010; rdata[1] = 8'h5A; rmode[1] = 2'b10;
    wait_grant(g, w);
    n_checks++; if (g !== 1) $display("FAIL to_gnt got %0d exp 1", g); else n_pass++;
    tick();
    n_checks++; if (m_start !== 1'b1) $display("FAIL to_start got %b exp 1", m_start); else n_pass++;
    early = 0;
    for (int j = 1; j < TO; j++) begin
      tick();
      if (ack !== '0 || err !== 1'b0) early++;
    end
    tick();
    n_checks++; if (early !== 0) $display("FAIL to_early_ack got %0d cycles exp 0", early); else n_pass++;
    n_checks++; if (ack !== 4'b0010) $display("FAIL to_ack got %b exp 0010", ack); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL to_err got %b exp 1", err); else n_pass++;
    n_checks++; if (rsp_data !== 8'h00) $display("FAIL to_rsp got %h exp 00", rsp_data); else n_pass++;
    n_checks++; if (ss_n !== 4'b1111) $display("FAIL to_ss_n got %b exp 1111", ss_n); else n_pass++;
    req = '0;
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL to_err_pulse got %b exp 0", err); else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_drop_and_stray();
    int g, w;
    bit sok;
    logic [DW-1:0] dst;
    req = 4'b0010; rdata[1] = 8'h21;
    wait_grant(g, w);
    tick();
    tick();
    req = '0;
    repeat (3) tick();
    m_done = 1'b1; m_rx = 8'h9C;
    tick();
    m_done = 1'b0;
    n_checks++; if (ack !== 4'b0010) $display("FAIL drop_ack got %b exp 0010", ack); else n_pass++;
    n_checks++; if (rsp_data !== 8'h9C) $display("FAIL drop_rsp got %h exp 9c", rsp_data); else n_pass++;
    tick();
    m_done = 1'b1; m_rx = 8'hFF;
    tick();
    m_done = 1'b0;
    n_checks++; if (ack !== 4'b0000 || gnt !== 4'b0000) $display("FAIL stray_gap got ack %b gnt %b exp 0000", ack, gnt); else n_pass++;
    n_checks++; if (rsp_data !== 8'h9C) $display("FAIL stray_gap_rsp got %h exp 9c", rsp_data); else n_pass++;
    m_done = 1'b1; m_rx = 8'hEE;
    tick();
    m_done = 1'b0;
    n_checks++; if (ack !== 4'b0000 || rsp_data !== 8'h9C) $display("FAIL stray_idle got ack %b rsp %h exp 0000 9c", ack, rsp_data); else n_pass++;
    req = 4'b0001; rdata[0] = 8'h01;
    wait_grant(g, w);
    n_checks++; if (g !== 0 || w !== 1) $display("FAIL stray_next_gnt got %0d after %0d exp 0 after 1", g, w); else n_pass++;
    finish_xfer(1, 8'h42, sok, dst);
    n_checks++; if (ack !== 4'b0001 || rsp_data !== 8'h42) $display("FAIL stray_next_ack got %b %h exp 0001 42", ack, rsp_data); else n_pass++;
    req = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_wait();
    int g, w, acks;
    bit sok;
    logic [DW-1:0] dst;
    req = 4'b1000; rdata[3] = 8'hD4;
    wait_grant(g, w);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (ss_n !== 4'b1111 || gnt !== 4'b0000) $display("FAIL rst_mid got ss_n %b gnt %b exp 1111 0000", ss_n, gnt); else n_pass++;
    n_checks++; if (m_din !== 8'h00 || m_start !== 1'b0) $display("FAIL rst_mid_master got din %h start %b exp 00 0", m_din, m_start); else n_pass++;
    req = '0;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ack !== '0) acks++;
    end
    rst_n = 1'b1;
    req = 4'b0100; rdata[2] = 8'h6B;
    wait_grant(g, w);
    n_checks++; if (acks !== 0 || ack !== '0) $display("FAIL rst_no_ack got %0d ack cycles exp 0", acks); else n_pass++;
    n_checks++; if (g !== 2 || w !== 1) $display("FAIL rst_regrant got %0d after %0d exp 2 after 1", g, w); else n_pass++;
    finish_xfer(2, 8'h17, sok, dst);
    req = '0;
    repeat (4) tick();
  endtask

  task automatic test_random();
    int g, w, e, mptr;
    bit sok;
    logic [DW-1:0] dst, od, rx;
    logic [NREQ-1:0] pm, nw;
    pulse_reset();
    mptr = NREQ - 1;
    pm = '0;
    for (int t = 0; t < 40; t++) begin
      if (pm == '0) begin
        pm = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++) if (pm[i]) begin rdata[i] = DW'($urandom); rmode[i] = 2'($urandom); end
        req = pm;
      end
      e = -1;
      for (int off = 1; off <= NREQ; off++) if (e < 0 && pm[(mptr + off) % NREQ]) e = (mptr + off) % NREQ;
      wait_grant(g, w);
      n_checks++; if (g !== e) $display("FAIL rnd_gnt got %0d exp %0d", g, e); else n_pass++;
      n_checks++; if (m_din !== rdata[e] || {m_cpol, m_cpha} !== rmode[e]) $display("FAIL rnd_setup got %h/%b exp %h/%b", m_din, {m_cpol, m_cpha}, rdata[e], rmode[e]); else n_pass++;
      n_checks++; if (ss_n !== ~gnt) $display("FAIL rnd_ss_n got %b exp %b", ss_n, ~gnt); else n_pass++;
      od = rdata[e];
      rdata[e] = DW'($urandom);
      rmode[e] = 2'($urandom);
      rx = DW'($urandom);
      finish_xfer($urandom_range(1, 30), rx, sok, dst);
      n_checks++; if (!sok || dst !== od) $display("FAIL rnd_capture got start %b din %h exp 1 %h", sok, dst, od); else n_pass++;
      n_checks++; if (ack !== NREQ'(1 << e) || rsp_data !== rx || err !== 1'b0) $display("FAIL rnd_ack got %b %h %b exp %b %h 0", ack, rsp_data, err, NREQ'(1 << e), rx); else n_pass++;
      pm[e] = 1'b0;
      nw = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~NREQ'(1 << e) & ~pm;
      for (int i = 0; i < NREQ; i++) if (nw[i]) begin rdata[i] = DW'($urandom); rmode[i] = 2'($urandom); end
      pm = pm | nw;
      req = pm;
      mptr = e;
    end
    req = '0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mode_switch();
    test_timeout();
    test_drop_and_stray();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit reached without finishing");
    $fatal(1);
  end

endmodule
